// File: rtl/add_pkg.sv
// Shared mode encodings and signed-range helpers for the add_pipe datapath.
package add_pkg;

   localparam logic [1:0] MODE_ADD  = 2'b00;
   localparam logic [1:0] MODE_SUB  = 2'b01;
   localparam logic [1:0] MODE_ACC  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Bit patterns of the most negative / most positive two's-complement value of width w.
   function automatic logic [63:0] signed_min(input int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

   function automatic logic [63:0] signed_max(input int unsigned w);
      return signed_min(w) - 64'd1;
   endfunction

endpackage

// File: rtl/add_core.sv
// Combinational add/sub/accumulate/load datapath with carry/borrow, signed
// overflow and optional signed saturation.
module add_core
   import add_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   input  logic             sat,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(signed_max(WIDTH));
   localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

   logic [WIDTH:0] raw;
   logic           sign_a;
   logic           sign_b;
   logic           sign_r;

   assign sign_a = a[WIDTH-1];
   assign sign_b = b[WIDTH-1];
   assign sign_r = raw[WIDTH-1];

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      raw   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (mode)
         MODE_ADD, MODE_ACC: begin
            raw   = {1'b0, a} + {1'b0, b};
            carry = raw[WIDTH];
            ovf   = (sign_a == sign_b) && (sign_r != sign_a);
         end
         MODE_SUB: begin
            // Top bit of the extended difference is the unsigned borrow.
            raw   = {1'b0, a} - {1'b0, b};
            carry = raw[WIDTH];
            ovf   = (sign_a != sign_b) && (sign_r != sign_a);
         end
         default: raw = {1'b0, b};
      endcase

      res = raw[WIDTH-1:0];
      if (SAT_EN && sat && ovf) begin
         res = sign_a ? MIN_VAL : MAX_VAL;
      end
   end

endmodule

// File: rtl/add_pipe.sv
// Registered adder/accumulator with valid/ready on both sides: latency 1,
// full throughput, and an accumulator fed from the same result as out.
module add_pipe
   import add_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [1:0]       mode,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             ovf,
   output logic [WIDTH-1:0] acc
);

   logic             use_acc;
   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic             res_carry;
   logic             res_ovf;

   // ACC and LOAD take the accumulator as operand A and in1 as operand B.
   assign use_acc = (mode == MODE_ACC) || (mode == MODE_LOAD);
   assign op_a    = use_acc ? acc : in1;
   assign op_b    = use_acc ? in1 : in2;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   add_core #(
      .WIDTH  (WIDTH),
      .SAT_EN (SAT_EN)
   ) u_core (
      .a     (op_a),
      .b     (op_b),
      .mode  (mode),
      .sat   (sat),
      .res   (res),
      .carry (res_carry),
      .ovf   (res_ovf)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out       <= '0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         acc       <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out       <= res;
         carry     <= res_carry;
         ovf       <= res_ovf;
         if (use_acc) begin
            acc <= res;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe (WIDTH=8, SAT_EN=1): an integer reference
// model predicts each accepted operation; results are checked on transfer.
module tb_add_pipe;

   localparam int         WIDTH = 8;
   localparam logic [1:0] M_ADD  = 2'b00;
   localparam logic [1:0] M_SUB  = 2'b01;
   localparam logic [1:0] M_ACC  = 2'b10;
   localparam logic [1:0] M_LOAD = 2'b11;

   typedef struct {
      logic [WIDTH-1:0] out;
      logic             carry;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [1:0]       mode;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             ovf;
   logic [WIDTH-1:0] acc;

   exp_t             sb[$];
   logic [WIDTH-1:0] model_acc;
   int               n_checks = 0;
   int               n_fail   = 0;

   always #5 clk = ~clk;

   add_pipe #(.WIDTH(WIDTH), .SAT_EN(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .mode      (mode),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .carry     (carry),
      .ovf       (ovf),
      .acc       (acc)
   );

   // Reference model in plain integer arithmetic.
   function automatic exp_t model(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                                  input logic s, input logic [7:0] a_in);
      exp_t       e;
      logic [7:0] opa;
      logic [7:0] opb;
      int         ua, ub, sa, sbv, ur, sr;
      opa = (m == M_ACC || m == M_LOAD) ? a_in : x;
      opb = (m == M_ADD || m == M_SUB) ? y : x;
      ua  = int'(opa);
      ub  = int'(opb);
      sa  = int'($signed(opa));
      sbv = int'($signed(opb));
      if (m == M_SUB) begin
         ur = ua - ub;
         sr = sa - sbv;
         e.carry = (ur < 0);
      end else if (m == M_LOAD) begin
         ur = ub;
         sr = sbv;
         e.carry = 1'b0;
      end else begin
         ur = ua + ub;
         sr = sa + sbv;
         e.carry = (ur > 255);
      end
      e.ovf = (sr > 127) || (sr < -128);
      e.out = ur[7:0];
      if (s && e.ovf) e.out = (sr > 127) ? 8'h7F : 8'h80;
      return e;
   endfunction

   // One clock: check handshake/acc state, pop on transfer, push on accept.
   task automatic step();
      exp_t e;
      bit   exp_ready;
      #1;
      exp_ready = (sb.size() == 0) || out_ready;
      n_checks++;
      if (out_valid !== (sb.size() != 0)) begin
         n_fail++;
         $display("FAIL out_valid: got %b want %b", out_valid, sb.size() != 0);
      end
      n_checks++;
      if (in_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL in_ready: got %b want %b", in_ready, exp_ready);
      end
      n_checks++;
      if (acc !== model_acc) begin
         n_fail++;
         $display("FAIL acc: got %h want %h", acc, model_acc);
      end
      if (sb.size() != 0 && out_ready) begin
         e = sb.pop_front();
         n_checks++;
         if ({out, carry, ovf} !== {e.out, e.carry, e.ovf}) begin
            n_fail++;
            $display("FAIL result: got out=%h c=%b v=%b want out=%h c=%b v=%b",
                     out, carry, ovf, e.out, e.carry, e.ovf);
         end
      end
      if (in_valid && exp_ready && !reset) begin
         e = model(mode, in1, in2, sat, model_acc);
         sb.push_back(e);
         if (mode == M_ACC || mode == M_LOAD) model_acc = e.out;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] x,
                        input logic [7:0] y, input logic s);
      in_valid = v;
      mode     = m;
      in1      = x;
      in2      = y;
      sat      = s;
   endtask

   task automatic expect_out(input string name, input logic [7:0] o, input logic c, input logic v);
      n_checks++;
      if ({out, carry, ovf} !== {o, c, v}) begin
         n_fail++;
         $display("FAIL %s: got out=%h c=%b v=%b want out=%h c=%b v=%b", name, out, carry, ovf, o, c, v);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, M_ADD, 8'h00, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      model_acc = '0;
      n_checks++;
      if ({out_valid, out, carry, ovf, acc, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b out=%h c=%b o=%b acc=%h rdy=%b want 0 00 0 0 00 1",
                  out_valid, out, carry, ovf, acc, in_ready);
      end
   endtask

   task automatic test_add_sub();
      drive(1'b1, M_ADD, 8'd200, 8'd100, 1'b0);
      step();
      expect_out("add_carry", 8'h2C, 1'b1, 1'b0);
      drive(1'b1, M_ADD, 8'd100, 8'd100, 1'b1);
      step();
      expect_out("add_sat", 8'h7F, 1'b0, 1'b1);
      drive(1'b1, M_ADD, 8'd100, 8'd100, 1'b0);
      step();
      expect_out("add_wrap", 8'hC8, 1'b0, 1'b1);
      drive(1'b1, M_SUB, 8'd5, 8'd10, 1'b0);
      step();
      expect_out("sub_borrow", 8'hFB, 1'b1, 1'b0);
      drive(1'b1, M_SUB, 8'h80, 8'h01, 1'b1);
      step();
      expect_out("sub_sat_min", 8'h80, 1'b0, 1'b1);
      drive(1'b0, M_ADD, 8'h00, 8'h00, 1'b0);
      repeat (2) step();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, M_LOAD, 8'd10, 8'hAA, 1'b0);
      step();
      expect_out("b2b_load", 8'd10, 1'b0, 1'b0);
      drive(1'b1, M_ACC, 8'd20, 8'h55, 1'b0);
      step();
      expect_out("b2b_acc1", 8'd30, 1'b0, 1'b0);
      drive(1'b1, M_ACC, 8'd30, 8'h00, 1'b0);
      step();
      expect_out("b2b_acc2", 8'd60, 1'b0, 1'b0);
      drive(1'b0, M_ADD, 8'h00, 8'h00, 1'b0);
      step();
      n_checks++;
      if (acc !== 8'd60) begin
         n_fail++;
         $display("FAIL b2b_acc_final: got %h want %h", acc, 8'd60);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      drive(1'b1, M_ADD, 8'd1, 8'd2, 1'b0);
      step();
      drive(1'b1, M_ADD, 8'd3, 8'd4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("stall_hold", 8'd3, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      step();
      expect_out("stall_release", 8'd7, 1'b0, 1'b0);
      drive(1'b0, M_ADD, 8'h00, 8'h00, 1'b0);
      repeat (2) step();
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      drive(1'b1, M_ADD, 8'd1, 8'd1, 1'b0);
      step();
      drive(1'b0, M_ADD, 8'h00, 8'h00, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb.delete();
      model_acc = '0;
      n_checks++;
      if ({out_valid, acc} !== {1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL mid_reset: got v=%b acc=%h want v=0 acc=00", out_valid, acc);
      end
      out_ready = 1'b1;
      drive(1'b1, M_ACC, 8'd5, 8'h00, 1'b0);
      step();
      expect_out("post_reset_acc", 8'd5, 1'b0, 1'b0);
      drive(1'b0, M_ADD, 8'h00, 8'h00, 1'b0);
      step();
      n_checks++;
      if (acc !== 8'd5) begin
         n_fail++;
         $display("FAIL post_reset_accval: got %h want %h", acc, 8'd5);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         out_ready = 1'($urandom_range(0, 3) != 0);
         step();
      end
      drive(1'b0, M_ADD, 8'h00, 8'h00, 1'b0);
      out_ready = 1'b1;
      repeat (2) step();
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_stall();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
